// File: rtl/synapse_weight_array_pkg.sv
// Shared types and constants for the synapse weight array feeding spiking_neuron.
package snn_pkg;

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_e;

  localparam int NEURON_IN_W = 8;
  localparam logic [NEURON_IN_W-1:0] SAT_MAX = 8'd255;

  localparam int N_INPUTS_DEF = 4;
  localparam int WEIGHT_W_DEF = 8;

  // Widest possible sum of n unsigned w-bit weights, so the adder can never wrap.
  function automatic int sum_width(input int n, input int w);
    return w + $clog2(n);
  endfunction

  localparam int SUM_W_DEF = sum_width(N_INPUTS_DEF, WEIGHT_W_DEF);

endpackage

// File: rtl/synapse_weight_array_if.sv
// Spike input, weight configuration and neuron-drive signals of the synapse array.
interface synapse_weight_array_if #(
  parameter int N_INPUTS = 4
);
  import snn_pkg::*;

  logic [N_INPUTS-1:0]    in_spikes;
  logic                   in_valid;
  logic                   cfg_start;
  logic                   cfg_valid;
  logic [7:0]             cfg_data;
  logic                   cfg_ready;
  logic                   weights_loaded;
  logic [NEURON_IN_W-1:0] neuron_input;

  modport master (
    output in_spikes, in_valid, cfg_start, cfg_valid, cfg_data,
    input  cfg_ready, weights_loaded, neuron_input
  );

  modport slave (
    input  in_spikes, in_valid, cfg_start, cfg_valid, cfg_data,
    output cfg_ready, weights_loaded, neuron_input
  );

endinterface

// File: rtl/synapse_weight_array_adder_tree.sv
// Combinational masked-weight adder; result clamped to the 8-bit neuron drive range.
module synapse_adder_tree
  import snn_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int WEIGHT_W = 8
) (
  input  logic [N_INPUTS*WEIGHT_W-1:0] weights_flat,
  input  logic [N_INPUTS-1:0]          mask,
  output logic [NEURON_IN_W-1:0]       sum_sat
);

  localparam int SW = sum_width(N_INPUTS, WEIGHT_W);

  logic [N_INPUTS-1:0][SW-1:0] masked;
  logic [SW-1:0]               sum;

  for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_lane
    assign masked[gi] = mask[gi] ? SW'(weights_flat[gi*WEIGHT_W +: WEIGHT_W]) : '0;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_INPUTS; i++) sum = sum + masked[i];
    sum_sat = (sum > SW'(SAT_MAX)) ? SAT_MAX : sum[NEURON_IN_W-1:0];
  end

endmodule

// File: rtl/synapse_weight_array.sv
// Weight registers, byte-serial load FSM and registered saturated drive for spiking_neuron.
module synapse_weight_array
  import snn_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int WEIGHT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  synapse_weight_array_if.slave  sif
);

  localparam int IDX_W = $clog2(N_INPUTS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [N_INPUTS-1:0][WEIGHT_W-1:0]  w_q, w_d;
  logic                               loaded_q, loaded_d;
  logic [NEURON_IN_W-1:0]             neuron_q, neuron_d;
  logic [NEURON_IN_W-1:0]             sum_sat;

  synapse_adder_tree #(
    .N_INPUTS (N_INPUTS),
    .WEIGHT_W (WEIGHT_W)
  ) u_adder (
    .weights_flat (w_q),
    .mask         (sif.in_spikes),
    .sum_sat      (sum_sat)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    w_d      = w_q;
    loaded_d = loaded_q;
    neuron_d = '0;
    unique case (state_q)
      RUN: begin
        // The start cycle still produces output from the old weights.
        neuron_d = sif.in_valid ? sum_sat : '0;
        if (sif.cfg_start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        // A restart outranks a coincident byte, which is dropped.
        if (sif.cfg_start) begin
          idx_d = '0;
        end else if (sif.cfg_valid) begin
          w_d[idx_q] = WEIGHT_W'(sif.cfg_data);
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            loaded_d = 1'b1;
            state_d  = RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      idx_q    <= '0;
      w_q      <= '0;
      loaded_q <= 1'b0;
      neuron_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      w_q      <= w_d;
      loaded_q <= loaded_d;
      neuron_q <= neuron_d;
    end
  end

  assign sif.cfg_ready      = (state_q == LOAD);
  assign sif.weights_loaded = loaded_q;
  assign sif.neuron_input   = neuron_q;

endmodule

// File: tb/tb_synapse_weight_array.sv
// Table vectors, hand-written load corner cases and random traffic against a sum/clamp model.
module tb_synapse_weight_array;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  synapse_weight_array_if #(.N_INPUTS(4)) sif ();

  synapse_weight_array #(.N_INPUTS(4), .WEIGHT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif.slave)
  );

  typedef struct {
    logic [3:0][7:0] w;
    logic [3:0]      sp;
    logic            v;
    int              exp;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int mw[4];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0][7:0] mkw(input int a, input int b, input int c, input int d);
    logic [3:0][7:0] r;
    r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
    return r;
  endfunction

  // Reference: plain integer sum of enabled weights, clamped to 255.
  function automatic int model(input logic [3:0] sp, input logic v);
    int s = 0;
    if (!v) return 0;
    for (int i = 0; i < 4; i++) if (sp[i]) s += mw[i];
    return (s > 255) ? 255 : s;
  endfunction

  task automatic idle();
    sif.cfg_start = 1'b0; sif.cfg_valid = 1'b0; sif.cfg_data = 8'd0;
    sif.in_valid  = 1'b0; sif.in_spikes = 4'b0;
  endtask

  task automatic load(input logic [3:0][7:0] b, input bit gaps);
    sif.cfg_start = 1'b1; sif.cfg_valid = 1'b0; sif.in_valid = 1'b0;
    step();
    sif.cfg_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (gaps && ($urandom % 2 == 0)) begin
        sif.cfg_valid = 1'b0;
        chk("load_gap_ready", int'(sif.cfg_ready), 1);
        step();
        chk("load_gap_hold", int'(sif.neuron_input), 0);
      end
      sif.cfg_valid = 1'b1; sif.cfg_data = b[i];
      chk("load_ready", int'(sif.cfg_ready), 1);
      step();
      chk("load_hold", int'(sif.neuron_input), 0);
      mw[i] = int'(b[i]);
    end
    sif.cfg_valid = 1'b0;
    chk("load_done_loaded", int'(sif.weights_loaded), 1);
    chk("load_done_ready", int'(sif.cfg_ready), 0);
  endtask

  task automatic apply(input string nm, input logic [3:0] sp, input logic v);
    sif.in_spikes = sp; sif.in_valid = v;
    step();
    chk(nm, int'(sif.neuron_input), model(sp, v));
    sif.in_valid = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    logic [3:0][7:0] rw;
    logic [3:0] rsp;
    logic rv;
    bit to;

    tbl.push_back('{mkw(10, 20, 30, 40),     4'b0101, 1'b1, 40});
    tbl.push_back('{mkw(200, 100, 0, 0),     4'b0011, 1'b1, 255});
    tbl.push_back('{mkw(200, 55, 0, 0),      4'b0011, 1'b1, 255});
    tbl.push_back('{mkw(200, 54, 0, 0),      4'b0011, 1'b1, 254});
    tbl.push_back('{mkw(10, 20, 30, 40),     4'b1111, 1'b0, 0});
    tbl.push_back('{mkw(10, 20, 30, 40),     4'b0000, 1'b1, 0});
    tbl.push_back('{mkw(255, 255, 255, 255), 4'b1111, 1'b1, 255});
    tbl.push_back('{mkw(1, 2, 3, 4),         4'b1000, 1'b1, 4});
    tbl.push_back('{mkw(60, 70, 80, 45),     4'b1111, 1'b1, 255});
    tbl.push_back('{mkw(60, 70, 80, 44),     4'b1111, 1'b1, 254});

    idle();
    for (int i = 0; i < 4; i++) mw[i] = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_neuron", int'(sif.neuron_input), 0);
    chk("reset_ready", int'(sif.cfg_ready), 0);
    chk("reset_loaded", int'(sif.weights_loaded), 0);
    #20 rst_n = 1'b1;
    step();
    apply("reset_zero_weights", 4'b1111, 1'b1);
    chk("reset_run_ready", int'(sif.cfg_ready), 0);

    // Restart mid-load with a coincident byte; the byte must be dropped.
    sif.cfg_start = 1'b1; step();
    sif.cfg_start = 1'b0; sif.cfg_valid = 1'b1;
    sif.in_spikes = 4'b1111; sif.in_valid = 1'b1;
    sif.cfg_data = 8'd5; step();
    sif.cfg_data = 8'd6; step();
    sif.cfg_start = 1'b1; sif.cfg_data = 8'd7; step();
    chk("restart_ready", int'(sif.cfg_ready), 1);
    chk("restart_loaded", int'(sif.weights_loaded), 0);
    chk("restart_hold", int'(sif.neuron_input), 0);
    sif.cfg_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sif.cfg_data = 8'(i + 1);
      step();
      chk("restart_load_hold", int'(sif.neuron_input), 0);
      mw[i] = i + 1;
    end
    sif.cfg_valid = 1'b0;
    chk("restart_loaded_after", int'(sif.weights_loaded), 1);
    apply("restart_w2", 4'b0100, 1'b1);
    chk("restart_w2_const", int'(sif.neuron_input), 3);
    apply("restart_all", 4'b1111, 1'b1);
    chk("restart_all_const", int'(sif.neuron_input), 10);

    foreach (tbl[k]) begin
      load(tbl[k].w, 1'b0);
      sif.in_spikes = tbl[k].sp; sif.in_valid = tbl[k].v;
      step();
      chk($sformatf("vec%0d", k), int'(sif.neuron_input), tbl[k].exp);
      sif.in_valid = 1'b0;
    end

    // Back-to-back stream: each output reflects the previous cycle's spikes.
    load(mkw(10, 20, 0, 0), 1'b0);
    for (int k = 0; k < 8; k++) begin
      sif.in_spikes = (k % 2 == 0) ? 4'b0001 : 4'b0010;
      sif.in_valid = 1'b1;
      step();
      chk("stream", int'(sif.neuron_input), (k % 2 == 0) ? 10 : 20);
    end

    // Start in RUN: that cycle's spikes still use the old weights.
    sif.cfg_start = 1'b1; sif.in_spikes = 4'b0011; sif.in_valid = 1'b1;
    step();
    chk("start_run_old_w", int'(sif.neuron_input), 30);
    chk("start_run_ready", int'(sif.cfg_ready), 1);
    sif.cfg_start = 1'b0; sif.cfg_valid = 1'b1; sif.in_spikes = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      sif.cfg_data = 8'(i + 1);
      step();
      chk("start_run_hold", int'(sif.neuron_input), 0);
      mw[i] = i + 1;
    end
    sif.cfg_valid = 1'b0;
    step();
    chk("first_run_new_w", int'(sif.neuron_input), 10);
    sif.in_valid = 1'b0;

    for (int n = 0; n < 300; n++) begin
      if ($urandom % 16 == 0) begin
        for (int i = 0; i < 4; i++)
          rw[i] = ($urandom % 2 == 0) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(0, 255));
        load(rw, 1'b1);
      end else begin
        rsp = 4'($urandom);
        rv  = ($urandom % 4 != 0);
        apply("rand", rsp, rv);
      end
    end

    // Asynchronous reset in the middle of a load.
    sif.cfg_start = 1'b1; step();
    sif.cfg_start = 1'b0; sif.cfg_valid = 1'b1;
    sif.cfg_data = 8'd9; step();
    sif.cfg_data = 8'd8; step();
    chk("midload_ready", int'(sif.cfg_ready), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_loaded", int'(sif.weights_loaded), 0);
    chk("midrst_ready", int'(sif.cfg_ready), 0);
    chk("midrst_neuron", int'(sif.neuron_input), 0);
    for (int i = 0; i < 4; i++) mw[i] = 0;
    idle();
    #3 rst_n = 1'b1;
    step();
    apply("midrst_cleared", 4'b1111, 1'b1);
    chk("midrst_cleared_const", int'(sif.neuron_input), 0);
    load(mkw(3, 0, 0, 0), 1'b0);
    apply("midrst_reload", 4'b0001, 1'b1);

    to = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/synapse_weight_array.md
Name: synapse_weight_array

Overview:
- Upstream stage of `spiking_neuron`.
- Converts a vector of binary input spikes into the 8-bit per-cycle drive `neuron_input` (weighted sum of active inputs, saturated to 8 bits).
- Weights are programmed at runtime through a byte-serial valid/ready configuration port.
- The output drives the neuron's `neuron_input` port directly.

Parameters:
- N_INPUTS, 4, number of presynaptic spike inputs (2..16).
- WEIGHT_W, 8, unsigned weight width in bits (fixed at 8 for this tapeout).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_spikes  input  N_INPUTS  presynaptic spikes for this cycle, bit i = input i
- in_valid  input  1  in_spikes qualifies this cycle
- cfg_start  input  1  single-cycle pulse: begin a weight (re)load at index 0
- cfg_valid  input  1  cfg_data holds a weight byte
- cfg_data  input  8  weight value, unsigned
- cfg_ready  output  1  block accepts cfg_data this cycle
- weights_loaded  output  1  a complete weight set has been written since reset
- neuron_input  output  8  saturated weighted sum, to `spiking_neuron`

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - All weights = 0.
  - State = RUN.
  - Load index = 0.
  - neuron_input = 0, cfg_ready = 0, weights_loaded = 0.
- States:
  - RUN → LOAD on cfg_start.
  - LOAD → RUN after the handshake at index N_INPUTS-1.
- RUN:
  - cfg_ready = 0; cfg_valid is ignored.
  - Each cycle, neuron_input <= (in_valid ? sat255(sum over i of in_spikes[i] ? w[i] : 0) : 0).
  - Registered output, latency exactly 1 cycle from in_spikes/in_valid.
- LOAD:
  - cfg_ready = 1 combinationally from state.
  - A handshake (cfg_valid & cfg_ready) writes w[idx] <= cfg_data and increments idx.
  - The handshake at idx = N_INPUTS-1 also sets idx <= 0, weights_loaded <= 1, and returns to RUN.
  - The new weights take effect on the first RUN cycle.
  - neuron_input is held at 0 for every LOAD cycle; in_spikes are discarded, not buffered.
- Arithmetic:
  - Internal sum width = WEIGHT_W + clog2(N_INPUTS), unsigned, no overflow possible.
  - Any sum > 255 is clamped to 255; no wrap-around ever reaches the output.
- Boundary conditions:
  - cfg_start during LOAD: idx restarts at 0; already-written weights are kept until overwritten; weights_loaded is unchanged.
  - cfg_start and a cfg handshake in the same cycle: cfg_start wins and the data byte is dropped.
  - cfg_start in RUN: moves to LOAD next cycle. That cycle's in_spikes still produce a valid output, using the old weights.
  - All in_spikes = 0 with in_valid = 1 produces 0.
  - A sum of exactly 255 passes through unclamped.
  - rst_n asserted mid-load: weights clear to 0, state returns to RUN, weights_loaded = 0.

Decomposition:
- Package `snn_pkg`:
  - state enum {RUN, LOAD};
  - NEURON_IN_W = 8;
  - SAT_MAX = 8'd255;
  - helper localparam for the sum width.
- Sub-module `synapse_adder_tree`:
  - purely combinational masked-weight adder with saturation;
  - input: flattened weight bus and spike mask; output: 8-bit saturated sum.
- The top level holds the weight registers, load FSM, index counter and output register.

Test Plan:
- Reset then RUN with in_spikes = 4'b1111, in_valid = 1 → neuron_input = 0 (weights 0); cfg_ready = 0; weights_loaded = 0.
- cfg_start, then bytes 10, 20, 30, 40 with cfg_valid held → cfg_ready high for 4 cycles, weights_loaded = 1 after the 4th byte. Then in_spikes = 4'b0101 → neuron_input = 40 one cycle later.
- Weights 200, 100, 0, 0 with in_spikes = 4'b0011 → neuron_input = 255 (saturated). Weights 200, 55 with in_spikes = 4'b0011 → 255 exactly, no clamp path.
- in_valid = 0 with in_spikes = 4'b1111 → neuron_input = 0. A gap-free spike stream alternating 0001/0010 with weights 10, 20 → outputs 10, 20, 10, ... each lagging by one cycle.
- cfg_start, 2 bytes (5, 6), cfg_start again coincident with byte 7, then bytes 1, 2, 3, 4 → final weights = 1, 2, 3, 4; byte 7 dropped; neuron_input = 0 throughout LOAD.
- rst_n pulsed low mid-load after 2 bytes → weights cleared, state RUN, weights_loaded = 0, neuron_input = 0 immediately (asynchronous).
